mem_rd_arbiter: RTL and testbench

- Sits directly downstream of the I-cache and D-cache memory read interfaces and merges both onto the single memory read port.
- Latches one request at a time and forwards it to memory. The owner stays locked until the burst's last beat, then the arbiter returns to idle.
- Carries I/O single-beat reads (len 0) and cache refills (len 7) unchanged.
- Reports protocol errors through a sticky status output.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_grant.sv | 25 ++
 rtl/mem_rd_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter: state encoding,
// master IDs and error-bit positions.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_REQ  = 3'b010,
    ARB_RESP = 3'b100
  } arb_state_e;

  localparam logic MST_IC = 1'b0;
  localparam logic MST_DC = 1'b1;

  localparam int ERR_LEN  = 0;
  localparam int ERR_SPUR = 1;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between I-cache and D-cache requesters.
// MEM_RD_ARB_RR_EN selects round-robin; otherwise the D-cache always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic ic_valid,
  input  logic dc_valid,
  input  logic last_grant,
  output logic grant
);

`ifdef MEM_RD_ARB_RR_EN
  always_comb begin
    if (ic_valid && dc_valid) grant = ~last_grant;
    else if (dc_valid)        grant = MST_DC;
    else                      grant = MST_IC;
  end
`else
  // Fixed priority ignores the IC valid and the grant history.
  logic unused_grant_inputs;
  assign unused_grant_inputs = ic_valid ^ last_grant;
  assign grant = dc_valid ? MST_DC : MST_IC;
`endif

endmodule

// File: rtl/mem_rd_arbiter.sv
// Merges I-cache and D-cache read requests onto one memory read port, one
// burst at a time. MEM_RD_ARB_RR_EN enables round-robin arbitration.
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              from_ic_rd_req_valid,
  input  logic [ADDR_W-1:0] from_ic_rd_req_addr,
  input  logic [LEN_W-1:0]  from_ic_rd_req_len,
  output logic              to_ic_rd_req_ready,
  output logic              to_ic_rd_rsp_valid,
  output logic [DATA_W-1:0] to_ic_rd_rsp_data,
  output logic              to_ic_rd_rsp_last,
  input  logic              from_ic_rd_rsp_ready,
  input  logic              from_dc_rd_req_valid,
  input  logic [ADDR_W-1:0] from_dc_rd_req_addr,
  input  logic [LEN_W-1:0]  from_dc_rd_req_len,
  output logic              to_dc_rd_req_ready,
  output logic              to_dc_rd_rsp_valid,
  output logic [DATA_W-1:0] to_dc_rd_rsp_data,
  output logic              to_dc_rd_rsp_last,
  input  logic              from_dc_rd_rsp_ready,
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  output logic [LEN_W-1:0]  to_mem_rd_req_len,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready,
  output logic [1:0]        arb_err
);

  arb_state_e        state, state_next;
  logic              owner;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W:0]    beat_cnt;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic              beat_fire;
  logic              owner_rsp_ready;

`ifdef MEM_RD_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= MST_IC;
    else if (accept) last_grant <= grant;
  end
`else
  assign last_grant = MST_IC;
`endif

  mem_arb_grant u_grant (
    .ic_valid   (from_ic_rd_req_valid),
    .dc_valid   (from_dc_rd_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign owner_rsp_ready    = (owner == MST_DC) ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;
  assign to_mem_rd_req_addr = addr;
  assign to_mem_rd_req_len  = len;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next          = state;
    accept              = 1'b0;
    beat_fire           = 1'b0;
    to_ic_rd_req_ready  = 1'b0;
    to_dc_rd_req_ready  = 1'b0;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = '0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = '0;
    to_dc_rd_rsp_last   = 1'b0;
    to_mem_rd_req_valid = 1'b0;
    // Drain stray memory beats while reset is held.
    to_mem_rd_rsp_ready = rst;
    unique case (state)
      ARB_IDLE: begin
        to_dc_rd_req_ready = (grant == MST_DC) && from_dc_rd_req_valid;
        to_ic_rd_req_ready = (grant == MST_IC) && from_ic_rd_req_valid;
        accept             = to_dc_rd_req_ready || to_ic_rd_req_ready;
        if (accept) state_next = ARB_REQ;
      end
      ARB_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        to_mem_rd_rsp_ready = owner_rsp_ready;
        if (owner == MST_DC) begin
          to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dc_rd_rsp_data  = from_mem_rd_rsp_data;
          to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_ic_rd_rsp_data  = from_mem_rd_rsp_data;
          to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        beat_fire = from_mem_rd_rsp_valid && owner_rsp_ready;
        if (beat_fire && from_mem_rd_rsp_last) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= MST_IC;
      addr     <= '0;
      len      <= '0;
      beat_cnt <= '0;
      arb_err  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner    <= grant;
        addr     <= (grant == MST_DC) ? from_dc_rd_req_addr : from_ic_rd_req_addr;
        len      <= (grant == MST_DC) ? from_dc_rd_req_len  : from_ic_rd_req_len;
        beat_cnt <= '0;
      end else if (beat_fire && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      // beat_cnt+1 != len+1 reduces to beat_cnt != len.
      if (beat_fire && from_mem_rd_rsp_last && (beat_cnt != {1'b0, len}))
        arb_err[ERR_LEN] <= 1'b1;
      if (from_mem_rd_rsp_valid && (state != ARB_RESP))
        arb_err[ERR_SPUR] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed testbench for mem_rd_arbiter; expectations adapt to MEM_RD_ARB_RR_EN.
module tb_mem_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              from_ic_rd_req_valid;
  logic [ADDR_W-1:0] from_ic_rd_req_addr;
  logic [LEN_W-1:0]  from_ic_rd_req_len;
  logic              to_ic_rd_req_ready;
  logic              to_ic_rd_rsp_valid;
  logic [DATA_W-1:0] to_ic_rd_rsp_data;
  logic              to_ic_rd_rsp_last;
  logic              from_ic_rd_rsp_ready;
  logic              from_dc_rd_req_valid;
  logic [ADDR_W-1:0] from_dc_rd_req_addr;
  logic [LEN_W-1:0]  from_dc_rd_req_len;
  logic              to_dc_rd_req_ready;
  logic              to_dc_rd_rsp_valid;
  logic [DATA_W-1:0] to_dc_rd_rsp_data;
  logic              to_dc_rd_rsp_last;
  logic              from_dc_rd_rsp_ready;
  logic              to_mem_rd_req_valid;
  logic [ADDR_W-1:0] to_mem_rd_req_addr;
  logic [LEN_W-1:0]  to_mem_rd_req_len;
  logic              from_mem_rd_req_ready;
  logic              from_mem_rd_rsp_valid;
  logic [DATA_W-1:0] from_mem_rd_rsp_data;
  logic              from_mem_rd_rsp_last;
  logic              to_mem_rd_rsp_ready;
  logic [1:0]        arb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .from_ic_rd_req_valid  (from_ic_rd_req_valid),
    .from_ic_rd_req_addr   (from_ic_rd_req_addr),
    .from_ic_rd_req_len    (from_ic_rd_req_len),
    .to_ic_rd_req_ready    (to_ic_rd_req_ready),
    .to_ic_rd_rsp_valid    (to_ic_rd_rsp_valid),
    .to_ic_rd_rsp_data     (to_ic_rd_rsp_data),
    .to_ic_rd_rsp_last     (to_ic_rd_rsp_last),
    .from_ic_rd_rsp_ready  (from_ic_rd_rsp_ready),
    .from_dc_rd_req_valid  (from_dc_rd_req_valid),
    .from_dc_rd_req_addr   (from_dc_rd_req_addr),
    .from_dc_rd_req_len    (from_dc_rd_req_len),
    .to_dc_rd_req_ready    (to_dc_rd_req_ready),
    .to_dc_rd_rsp_valid    (to_dc_rd_rsp_valid),
    .to_dc_rd_rsp_data     (to_dc_rd_rsp_data),
    .to_dc_rd_rsp_last     (to_dc_rd_rsp_last),
    .from_dc_rd_rsp_ready  (from_dc_rd_rsp_ready),
    .to_mem_rd_req_valid   (to_mem_rd_req_valid),
    .to_mem_rd_req_addr    (to_mem_rd_req_addr),
    .to_mem_rd_req_len     (to_mem_rd_req_len),
    .from_mem_rd_req_ready (from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid (from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data  (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last  (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready),
    .arb_err               (arb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request already accepted (arbiter in REQ): check the memory request,
  // hold it one cycle, hand it off and stream nbeats beats back.
  task automatic run_burst(input bit dc, input logic [31:0] a, input logic [7:0] l,
                           input int nbeats, input logic [31:0] base, input bit stall);
    int          i;
    int          cyc;
    logic        rdy;
    logic        ov, ol, nv;
    logic [31:0] od, nd, exp_d;
    #1;
    checks++;
    if ({to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_req_len} !== {1'b1, a, l}) begin
      errors++;
      $display("FAIL mem_req: got v=%b a=%h l=%0d expected v=1 a=%h l=%0d",
               to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_req_len, a, l);
    end
    tick();
    checks++;
    if ({to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_req_len,
         to_ic_rd_req_ready, to_dc_rd_req_ready} !== {1'b1, a, l, 2'b00}) begin
      errors++;
      $display("FAIL mem_req_hold: got v=%b a=%h l=%0d rdy=%b%b expected v=1 a=%h l=%0d rdy=00",
               to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_req_len,
               to_ic_rd_req_ready, to_dc_rd_req_ready, a, l);
    end
    from_mem_rd_req_ready = 1'b1;
    tick();
    from_mem_rd_req_ready = 1'b0;
    i   = 0;
    cyc = 0;
    while (i < nbeats && cyc < 64) begin
      rdy   = stall ? (cyc % 2 == 0) : 1'b1;
      exp_d = base + 32'(i);
      if (dc) begin from_dc_rd_rsp_ready = rdy; from_ic_rd_rsp_ready = ~rdy; end
      else    begin from_ic_rd_rsp_ready = rdy; from_dc_rd_rsp_ready = ~rdy; end
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = exp_d;
      from_mem_rd_rsp_last  = (i == nbeats - 1);
      #1;
      ov = dc ? to_dc_rd_rsp_valid : to_ic_rd_rsp_valid;
      od = dc ? to_dc_rd_rsp_data  : to_ic_rd_rsp_data;
      ol = dc ? to_dc_rd_rsp_last  : to_ic_rd_rsp_last;
      nv = dc ? to_ic_rd_rsp_valid : to_dc_rd_rsp_valid;
      nd = dc ? to_ic_rd_rsp_data  : to_dc_rd_rsp_data;
      checks++;
      if ({ov, od, ol, to_mem_rd_rsp_ready} !== {1'b1, exp_d, (i == nbeats - 1), rdy}) begin
        errors++;
        $display("FAIL beat%0d: got v=%b d=%h last=%b mem_rdy=%b expected v=1 d=%h last=%b mem_rdy=%b",
                 i, ov, od, ol, to_mem_rd_rsp_ready, exp_d, (i == nbeats - 1), rdy);
      end
      checks++;
      if ({nv, nd} !== 33'b0) begin
        errors++;
        $display("FAIL non_owner_beat%0d: got v=%b d=%h expected v=0 d=0", i, nv, nd);
      end
      tick();
      if (rdy) i++;
      cyc++;
    end
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_last  = 1'b0;
    from_ic_rd_rsp_ready  = 1'b0;
    from_dc_rd_rsp_ready  = 1'b0;
    checks++;
    if (i != nbeats) begin
      errors++;
      $display("FAIL burst_timeout: got %0d beats expected %0d", i, nbeats);
    end
  endtask

  // Caller drives the request valids; this checks the grant, drops the
  // winner's valid after the accept edge and serves its burst.
  task automatic grant_and_serve(input bit dc, input logic [31:0] a, input logic [7:0] l,
                                 input int nbeats, input logic [31:0] base, input bit stall);
    #1;
    checks++;
    if ({to_dc_rd_req_ready, to_ic_rd_req_ready} !== (dc ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: got dc_rdy=%b ic_rdy=%b expected %s",
               to_dc_rd_req_ready, to_ic_rd_req_ready, dc ? "dc" : "ic");
    end
    tick();
    if (dc) from_dc_rd_req_valid = 1'b0;
    else    from_ic_rd_req_valid = 1'b0;
    run_burst(dc, a, l, nbeats, base, stall);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({to_mem_rd_rsp_ready, to_mem_rd_req_valid, to_ic_rd_req_ready, to_dc_rd_req_ready,
         to_ic_rd_rsp_valid, to_dc_rd_rsp_valid, arb_err} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got mrdy=%b mv=%b ir=%b dr=%b iv=%b dv=%b err=%b expected mrdy=1 rest 0",
               to_mem_rd_rsp_ready, to_mem_rd_req_valid, to_ic_rd_req_ready, to_dc_rd_req_ready,
               to_ic_rd_rsp_valid, to_dc_rd_rsp_valid, arb_err);
    end
    checks++;
    if ({to_mem_rd_req_addr, to_mem_rd_req_len} !== 40'h0) begin
      errors++;
      $display("FAIL reset_addr_len: got a=%h l=%0d expected 0",
               to_mem_rd_req_addr, to_mem_rd_req_len);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (to_mem_rd_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp_ready: got %b expected 0", to_mem_rd_rsp_ready);
    end
  endtask

  task automatic test_dc_refill();
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h0000_1000;
    from_dc_rd_req_len   = 8'd7;
    grant_and_serve(1'b1, 32'h0000_1000, 8'd7, 8, 32'hA0, 1'b0);
    #1;
    checks++;
    if (arb_err !== 2'b00) begin
      errors++;
      $display("FAIL refill_err: got %b expected 00", arb_err);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    from_ic_rd_req_valid = 1'b1;
    from_ic_rd_req_addr  = 32'h0000_2000;
    from_ic_rd_req_len   = 8'd7;
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h8000_0004;
    from_dc_rd_req_len   = 8'd0;
    grant_and_serve(1'b1, 32'h8000_0004, 8'd0, 1, 32'hDEAD_BEEF, 1'b0);
    // IC still waiting; DC asks again so both are valid at the next decision.
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h8000_0008;
    from_dc_rd_req_len   = 8'd0;
`ifdef MEM_RD_ARB_RR_EN
    grant_and_serve(1'b0, 32'h0000_2000, 8'd7, 8, 32'hB0, 1'b0);
    grant_and_serve(1'b1, 32'h8000_0008, 8'd0, 1, 32'hCAFE_0001, 1'b0);
`else
    grant_and_serve(1'b1, 32'h8000_0008, 8'd0, 1, 32'hCAFE_0001, 1'b0);
    grant_and_serve(1'b0, 32'h0000_2000, 8'd7, 8, 32'hB0, 1'b0);
`endif
    #1;
    checks++;
    if (arb_err !== 2'b00) begin
      errors++;
      $display("FAIL simultaneous_err: got %b expected 00", arb_err);
    end
  endtask

  task automatic test_backpressure();
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h0000_3000;
    from_dc_rd_req_len   = 8'd7;
    grant_and_serve(1'b1, 32'h0000_3000, 8'd7, 8, 32'h30, 1'b1);
  endtask

  task automatic test_short_burst();
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h0000_4000;
    from_dc_rd_req_len   = 8'd7;
    grant_and_serve(1'b1, 32'h0000_4000, 8'd7, 4, 32'h40, 1'b0);
    #1;
    checks++;
    if (arb_err !== 2'b01) begin
      errors++;
      $display("FAIL short_burst_err: got %b expected 01", arb_err);
    end
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h0000_5000;
    from_dc_rd_req_len   = 8'd0;
    grant_and_serve(1'b1, 32'h0000_5000, 8'd0, 1, 32'h50, 1'b0);
    #1;
    checks++;
    if (arb_err !== 2'b01) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 01", arb_err);
    end
  endtask

  task automatic test_spurious_and_reset();
    from_mem_rd_rsp_valid = 1'b1;
    from_mem_rd_rsp_data  = 32'h5555_AAAA;
    #1;
    checks++;
    if ({to_mem_rd_rsp_ready, to_ic_rd_rsp_valid, to_dc_rd_rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL spurious_accept: got mrdy=%b iv=%b dv=%b expected 000",
               to_mem_rd_rsp_ready, to_ic_rd_rsp_valid, to_dc_rd_rsp_valid);
    end
    tick();
    from_mem_rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if (arb_err !== 2'b11) begin
      errors++;
      $display("FAIL spurious_err: got %b expected 11", arb_err);
    end
    // Start a refill and reset it on its fourth beat.
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h0000_6000;
    from_dc_rd_req_len   = 8'd7;
    tick();
    from_dc_rd_req_valid  = 1'b0;
    from_mem_rd_req_ready = 1'b1;
    tick();
    from_mem_rd_req_ready = 1'b0;
    from_dc_rd_rsp_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = 32'hC0 + 32'(k);
      tick();
    end
    from_mem_rd_rsp_data = 32'hC3;
    rst = 1'b1;
    #1;
    checks++;
    if ({to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last, to_mem_rd_req_valid,
         to_mem_rd_req_addr, to_mem_rd_rsp_ready, arb_err} !== {35'h0, 32'h0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_burst: got dv=%b dd=%h dl=%b mv=%b ma=%h mrdy=%b err=%b expected all 0 except mrdy=1",
               to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last, to_mem_rd_req_valid,
               to_mem_rd_req_addr, to_mem_rd_rsp_ready, arb_err);
    end
    tick();
    checks++;
    if ({to_mem_rd_rsp_ready, arb_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_drain: got mrdy=%b err=%b expected mrdy=1 err=00",
               to_mem_rd_rsp_ready, arb_err);
    end
    rst                   = 1'b0;
    from_mem_rd_rsp_valid = 1'b0;
    from_dc_rd_rsp_ready  = 1'b0;
    #1;
    checks++;
    if ({to_mem_rd_rsp_ready, arb_err} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset: got mrdy=%b err=%b expected 0 00", to_mem_rd_rsp_ready, arb_err);
    end
    from_dc_rd_req_valid = 1'b1;
    from_dc_rd_req_addr  = 32'h0000_7000;
    from_dc_rd_req_len   = 8'd0;
    grant_and_serve(1'b1, 32'h0000_7000, 8'd0, 1, 32'h77, 1'b0);
    #1;
    checks++;
    if (arb_err !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_err: got %b expected 00", arb_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                   = 1'b1;
    from_ic_rd_req_valid  = 1'b0;
    from_ic_rd_req_addr   = '0;
    from_ic_rd_req_len    = '0;
    from_ic_rd_rsp_ready  = 1'b0;
    from_dc_rd_req_valid  = 1'b0;
    from_dc_rd_req_addr   = '0;
    from_dc_rd_req_len    = '0;
    from_dc_rd_rsp_ready  = 1'b0;
    from_mem_rd_req_ready = 1'b0;
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_data  = '0;
    from_mem_rd_rsp_last  = 1'b0;
    test_reset();
    test_dc_refill();
    test_simultaneous();
    test_backpressure();
    test_short_burst();
    test_spurious_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
